// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: FSM encoding, phase lengths, element slice.
// Latency: none (types, constant functions and a slice macro only).
// Backpressure: not applicable.
`ifndef SYSTOLIC_OPERAND_FEEDER_ELEM
`define SYSTOLIC_OPERAND_FEEDER_ELEM
// Element (r,c) of a flattened row-major NxN matrix of W-bit elements.
`define ELEM(mat, r, c, W, N) mat[(W)*((r)*(N)+(c)) +: (W)]
`endif

package systolic_operand_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Skewed streaming takes 2N-1 steps: lane N-1 starts N-1 steps late.
    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    // Zero flush lets the last product travel through the remaining N-1 PEs.
    function automatic int flush_len(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_skew_lane_sel.sv
// Per-lane diagonal-skew selector: picks A[lane][k-lane] (row) or B[k-lane][lane] (column).
// Latency: purely combinational.
// Backpressure: none; the parent decides when the result is registered.
module skew_lane_sel
    import systolic_operand_feeder_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 3,
    parameter int KW = $clog2(2 * N)
) (
    input  logic [KW-1:0]    lane_i,
    input  logic [KW-1:0]    k_i,
    input  logic             is_row_i,
    input  logic [W*N*N-1:0] mat_i,
    output logic [W-1:0]     elem_o,
    output logic             vld_o
);

    // Lane carries a real element only while k-lane falls inside the matrix.
    always_comb begin
        int off;
        int r;
        int c;
        off    = int'(k_i) - int'(lane_i);
        vld_o  = (off >= 0) && (off < N);
        r      = is_row_i ? int'(lane_i) : off;
        c      = is_row_i ? off : int'(lane_i);
        elem_o = '0;
        for (int rr = 0; rr < N; rr++) begin
            for (int cc = 0; cc < N; cc++) begin
                if (vld_o && (rr == r) && (cc == c)) begin
                    elem_o = `ELEM(mat_i, rr, cc, W, N);
                end
            end
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Captures one A/B pair, streams skewed rows/columns into the array, flushes, then pulses done.
// Latency: first lanes 1 cycle after capture; o_done 3N-1 cycles, o_ready 3N cycles after capture.
// Backpressure: o_ready only in IDLE with i_en; i_en=0 freezes every register and output.
module systolic_operand_feeder
    import systolic_operand_feeder_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic [W*N-1:0]   o_west,
    output logic [N-1:0]     o_west_vld,
    output logic [W*N-1:0]   o_north,
    output logic [N-1:0]     o_north_vld,
    output logic             o_clear,
    output logic             o_busy,
    output logic             o_done
);

    localparam int KW = $clog2(2 * N);
    localparam logic [KW-1:0] K_STREAM_LAST = KW'(stream_len(N) - 1);
    localparam logic [KW-1:0] K_FLUSH_LAST  = KW'(flush_len(N) - 1);

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [W*N*N-1:0]   a_q, a_d, b_q, b_d;
    logic [W*N-1:0]     west_q, north_q;
    logic [N-1:0]       west_vld_q, north_vld_q;
    logic               clear_q, done_q;

    logic [W*N-1:0]     west_sel, north_sel;
    logic [N-1:0]       west_sel_vld, north_sel_vld;

    assign o_ready     = (state_q == ST_IDLE) & i_en;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_west      = west_q;
    assign o_west_vld  = west_vld_q;
    assign o_north     = north_q;
    assign o_north_vld = north_vld_q;
    assign o_clear     = clear_q;
    assign o_done      = done_q;

    // Next state, step counter and operand capture; nothing advances while i_en is low.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        if (i_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_d     = i_A;
                        b_d     = i_B;
                        state_d = ST_STREAM;
                        k_d     = '0;
                    end
                end
                ST_STREAM: begin
                    if (k_q == K_STREAM_LAST) begin
                        state_d = ST_FLUSH;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (k_q == K_FLUSH_LAST) begin
                        state_d = ST_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // State, counter and captured operands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Selectors look at next-step values so the registered lanes line up with the state they belong to.
    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam logic [KW-1:0] LANE = KW'(g);

        skew_lane_sel #(.W(W), .N(N), .KW(KW)) u_west (
            .lane_i  (LANE),
            .k_i     (k_d),
            .is_row_i(1'b1),
            .mat_i   (a_d),
            .elem_o  (west_sel[W*g +: W]),
            .vld_o   (west_sel_vld[g])
        );

        skew_lane_sel #(.W(W), .N(N), .KW(KW)) u_north (
            .lane_i  (LANE),
            .k_i     (k_d),
            .is_row_i(1'b0),
            .mat_i   (b_d),
            .elem_o  (north_sel[W*g +: W]),
            .vld_o   (north_sel_vld[g])
        );
    end

    // Registered outputs: lanes only in STREAM, clear on step 0, done in DONE; held during stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            west_q      <= '0;
            west_vld_q  <= '0;
            north_q     <= '0;
            north_vld_q <= '0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
        end else if (i_en) begin
            west_q      <= (state_d == ST_STREAM) ? west_sel      : '0;
            west_vld_q  <= (state_d == ST_STREAM) ? west_sel_vld  : '0;
            north_q     <= (state_d == ST_STREAM) ? north_sel     : '0;
            north_vld_q <= (state_d == ST_STREAM) ? north_sel_vld : '0;
            clear_q     <= (state_d == ST_STREAM) && (k_d == '0);
            done_q      <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder (N=3, W=16): table-driven stream checks plus corner sequences.
// Latency: checks capture-to-done and capture-to-ready distances and stall extension.
// Backpressure: exercises held i_valid while busy and i_en stalls.
module tb_systolic_operand_feeder;

    localparam int W = 16;
    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst, en, valid;
    logic [W*N*N-1:0] A, B;
    logic             ready, clear, busy, done;
    logic [W*N-1:0]   west, north;
    logic [N-1:0]     west_vld, north_vld;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [47:0] west;
        logic [2:0]  wv;
        logic [47:0] north;
        logic [2:0]  nv;
        logic        clr;
    } vec_t;

    vec_t       tv[5];
    logic [2:0] vp[5];

    always #5 clk = ~clk;

    systolic_operand_feeder #(.W(W), .N(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_A        (A),
        .i_B        (B),
        .o_west     (west),
        .o_west_vld (west_vld),
        .o_north    (north),
        .o_north_vld(north_vld),
        .o_clear    (clear),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [143:0] mat_seq(input int base);
        logic [143:0] m;
        for (int e = 0; e < 9; e++) m[e*16 +: 16] = 16'(base + e);
        return m;
    endfunction

    function automatic logic [143:0] mat_ident();
        logic [143:0] m;
        m = '0;
        for (int d = 0; d < 3; d++) m[(d*3+d)*16 +: 16] = 16'd1;
        return m;
    endfunction

    function automatic logic [47:0] lanes3(input logic [15:0] l2, input logic [15:0] l1, input logic [15:0] l0);
        return {l2, l1, l0};
    endfunction

    function automatic logic [47:0] ones_mask(input logic [2:0] v);
        return {v[2] ? 16'hffff : 16'h0, v[1] ? 16'hffff : 16'h0, v[0] ? 16'hffff : 16'h0};
    endfunction

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int dn;

        tv[0] = '{lanes3(0, 0, 1), 3'b001, lanes3(0, 0, 1), 3'b001, 1'b1};
        tv[1] = '{lanes3(0, 4, 2), 3'b011, lanes3(0, 0, 0), 3'b011, 1'b0};
        tv[2] = '{lanes3(7, 5, 3), 3'b111, lanes3(0, 1, 0), 3'b111, 1'b0};
        tv[3] = '{lanes3(8, 6, 0), 3'b110, lanes3(0, 0, 0), 3'b110, 1'b0};
        tv[4] = '{lanes3(9, 0, 0), 3'b100, lanes3(1, 0, 0), 3'b100, 1'b0};
        vp[0] = 3'b001; vp[1] = 3'b011; vp[2] = 3'b111; vp[3] = 3'b110; vp[4] = 3'b100;

        rst = 1'b0; en = 1'b1; valid = 1'b0; A = '0; B = '0;
        #2 rst = 1'b1;
        #1;
        chk("reset ready", ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset lanes", {west, north}, 96'd0);
        chk("reset vld/clear/done", {west_vld, north_vld, clear, done}, 8'd0);
        tick(); tick();
        rst = 1'b0;

        // Test 1: A=1..9, B=identity, single handshake.
        A = mat_seq(1); B = mat_ident(); valid = 1'b1;
        chk("t1 ready before capture", ready, 1'b1);
        tick();
        valid = 1'b0; A = '0; B = '0;
        chk("t1 ready after capture", ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk($sformatf("t1 west k%0d", k), west, tv[k].west);
            chk($sformatf("t1 west_vld k%0d", k), west_vld, tv[k].wv);
            chk($sformatf("t1 north k%0d", k), north, tv[k].north);
            chk($sformatf("t1 north_vld k%0d", k), north_vld, tv[k].nv);
            chk($sformatf("t1 clear k%0d", k), clear, tv[k].clr);
        end
        tick();
        chk("t1 flush lanes", {west, north, west_vld, north_vld}, 102'd0);
        chk("t1 flush clear/done", {clear, done}, 2'b00);
        tick();
        chk("t1 flush2 done", done, 1'b0);
        tick();
        chk("t1 done in cycle 8", done, 1'b1);
        chk("t1 ready in done", ready, 1'b0);
        tick();
        chk("t1 done pulse ends", done, 1'b0);
        chk("t1 ready in cycle 9", ready, 1'b1);
        chk("t1 busy in cycle 9", busy, 1'b0);

        // Test 2: i_valid held while busy; one capture per job, 9 edges apart.
        A = mat_seq(1); B = mat_ident(); valid = 1'b1;
        tick();
        e = 0;
        A = mat_seq(101); B = mat_seq(21);
        tick(); tick(); e = 2;
        chk("t2 job1 west latched", west, tv[2].west);
        chk("t2 job1 north latched", north, tv[2].north);
        while (!clear && e < 30) begin
            tick();
            e++;
        end
        chk("t2 second capture edge", e, 9);
        chk("t2 job2 west k0", west, lanes3(0, 0, 101));
        valid = 1'b0;
        tick(); tick();
        chk("t2 job2 west k2", west, lanes3(107, 105, 103));
        chk("t2 job2 north k2", north, lanes3(23, 25, 27));
        wait_idle("t2 idle");
        tick();
        chk("t2 no third capture", busy, 1'b0);

        // Test 3: stall 3 cycles at k=2, then at DONE.
        A = mat_seq(1); B = mat_ident(); valid = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick(); e = 2;
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick(); e++;
            chk($sformatf("t3 stall west s%0d", s), west, tv[2].west);
            chk($sformatf("t3 stall vld s%0d", s), west_vld, 3'b111);
        end
        chk("t3 stall ready", ready, 1'b0);
        en = 1'b1;
        tick(); e++;
        chk("t3 resume west k3", west, tv[3].west);
        while (!done && e < 40) begin
            tick();
            e++;
        end
        chk("t3 done edges with stall", e, 10);
        en = 1'b0;
        tick();
        chk("t3 done extends in stall", done, 1'b1);
        en = 1'b1;
        tick();
        chk("t3 done ends", done, 1'b0);
        chk("t3 ready after done", ready, 1'b1);

        // Test 4a: reset mid-STREAM clears lanes before the next edge.
        A = mat_seq(1); B = mat_ident(); valid = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("t4 stream reset lanes", {west, west_vld, north_vld}, 54'd0);
        chk("t4 stream reset ready", ready, 1'b1);
        tick();
        rst = 1'b0;

        // Test 4b: reset mid-FLUSH aborts with no done.
        A = mat_seq(1); B = mat_ident(); valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        chk("t4 in flush busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t4 flush reset busy", busy, 1'b0);
        chk("t4 flush reset ready", ready, 1'b1);
        chk("t4 flush reset outs", {west, north, west_vld, north_vld, clear, done}, 104'd0);
        tick(); tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dn++;
        end
        chk("t4 no done after abort", dn, 0);
        chk("t4 idle after abort", busy, 1'b0);

        // Test 5: all-ones operands, no truncation.
        A = '1; B = '1; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            chk($sformatf("t5 west k%0d", k), west, ones_mask(vp[k]));
            chk($sformatf("t5 west_vld k%0d", k), west_vld, vp[k]);
            chk($sformatf("t5 north k%0d", k), north, ones_mask(vp[k]));
            chk($sformatf("t5 north_vld k%0d", k), north_vld, vp[k]);
        end
        wait_idle("t5 idle");

        // Test 6: valid with i_en low in IDLE.
        en = 1'b0; valid = 1'b1; A = mat_seq(1); B = mat_ident();
        #1;
        chk("t6 ready with en low", ready, 1'b0);
        tick(); tick();
        chk("t6 no capture busy", busy, 1'b0);
        chk("t6 no capture clear", clear, 1'b0);
        en = 1'b1;
        #1;
        chk("t6 ready with en high", ready, 1'b1);
        tick();
        valid = 1'b0;
        chk("t6 captured busy", busy, 1'b1);
        chk("t6 captured clear", clear, 1'b1);
        chk("t6 captured west k0", west, tv[0].west);
        wait_idle("t6 idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
